ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit beside the ALU in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO against architectural HI/LO registers. Operands arrive already forwarded, identical to the ALU operand path. o_busy feeds the hazard unit to stall IF/ID/EX; i_flush aborts speculative work.

---
 rtl/ex_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//   Multi-cycle multiply/divide unit that sits beside the ALU in EX. It runs
//   MULT, MULTU, DIV and DIVU against the architectural HI/LO registers and
//   also handles MTHI and MTLO. Signed operations are done on magnitudes, and
//   the signs are applied in a single FIX cycle before HI/LO are written.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   i_valid       in   operation request this cycle
//   i_op          in   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NOP
//   i_rs_data     in   multiplicand / dividend / MT source
//   i_rt_data     in   multiplier / divisor
//   i_flush       in   abort any in-flight operation, block acceptance
//   o_busy        out  high while an operation is in flight
//   o_done        out  one-cycle pulse after a MULT/DIV commits
//   o_div_by_zero out  one-cycle pulse with o_done for divide by zero
//   o_hi, o_lo    out  committed HI / LO registers
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int DATA_WIDTH         = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [DATA_WIDTH-1:0] i_rt_data,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_by_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int B  = MUL_BITS_PER_CYCLE;
    localparam int N  = W / B;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement negation of a word when neg is set.
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic neg);
        logic [W-1:0] r;
        if (neg) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of a double word when neg is set.
    function automatic logic [2*W-1:0] cond_neg_dw(input logic [2*W-1:0] v, input logic neg);
        logic [2*W-1:0] r;
        if (neg) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              dbz_r;
    logic              dbz_pending_r;
    logic              is_div_r;
    logic              neg_res_r;    // product or quotient must be negated
    logic              neg_rem_r;    // remainder takes the dividend's sign
    logic [CW-1:0]     cnt_r;
    logic [W-1:0]      opb_r;        // multiplicand (MUL) or divisor (DIV)
    // MUL: {partial upper, multiplier shifting out}; DIV: {remainder, quotient}
    logic [2*W-1:0]    prod_r;
    logic [W-1:0]      hi_r;
    logic [W-1:0]      lo_r;

    logic              signed_op_s;
    logic              rs_neg_s;
    logic              rt_neg_s;
    logic [W-1:0]      rs_mag_s;
    logic [W-1:0]      rt_mag_s;
    logic [W+B-1:0]    partial_s;
    logic [W+B-1:0]    upper_sum_s;
    logic [2*W-1:0]    mul_next_s;
    logic [W:0]        shifted_s;
    logic [W:0]        diff_s;
    logic [2*W-1:0]    div_next_s;
    logic [2*W-1:0]    mul_res_s;
    logic [W-1:0]      quo_res_s;
    logic [W-1:0]      rem_res_s;

    // Operand magnitudes for the request currently on the inputs.
    always_comb begin
        signed_op_s = (i_op == OP_MULT) || (i_op == OP_DIV);
        rs_neg_s    = signed_op_s & i_rs_data[W-1];
        rt_neg_s    = signed_op_s & i_rt_data[W-1];
        rs_mag_s    = cond_neg_w(i_rs_data, rs_neg_s);
        rt_mag_s    = cond_neg_w(i_rt_data, rt_neg_s);
    end

    // One shift-add step retiring B multiplier bits from the low end of prod_r.
    always_comb begin
        partial_s   = {{B{1'b0}}, opb_r} * {{W{1'b0}}, prod_r[B-1:0]};
        upper_sum_s = {{B{1'b0}}, prod_r[2*W-1:W]} + partial_s;
        mul_next_s  = {upper_sum_s, prod_r[W-1:B]};
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract.
    always_comb begin
        shifted_s = {prod_r[2*W-1:W], prod_r[W-1]};
        diff_s    = shifted_s - {1'b0, opb_r};
        if (diff_s[W]) begin
            div_next_s = {shifted_s[W-1:0], prod_r[W-2:0], 1'b0};
        end else begin
            div_next_s = {diff_s[W-1:0], prod_r[W-2:0], 1'b1};
        end
    end

    // Sign correction applied in FIX. MIN_INT / -1 wraps back to MIN_INT here.
    always_comb begin
        mul_res_s = cond_neg_dw(prod_r, neg_res_r);
        quo_res_s = cond_neg_w(prod_r[W-1:0], neg_res_r);
        rem_res_s = cond_neg_w(prod_r[2*W-1:W], neg_rem_r);
    end

    // Control FSM, iteration datapath and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            dbz_r         <= 1'b0;
            dbz_pending_r <= 1'b0;
            is_div_r      <= 1'b0;
            neg_res_r     <= 1'b0;
            neg_rem_r     <= 1'b0;
            cnt_r         <= '0;
            opb_r         <= '0;
            prod_r        <= '0;
            hi_r          <= '0;
            lo_r          <= '0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            if (i_flush) begin
                // Flush beats everything, including a pending FIX write.
                state_r       <= S_IDLE;
                busy_r        <= 1'b0;
                dbz_pending_r <= 1'b0;
                cnt_r         <= '0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (i_valid) begin
                            case (i_op)
                                OP_MULT, OP_MULTU: begin
                                    state_r   <= S_MUL;
                                    busy_r    <= 1'b1;
                                    is_div_r  <= 1'b0;
                                    neg_res_r <= rs_neg_s ^ rt_neg_s;
                                    neg_rem_r <= 1'b0;
                                    cnt_r     <= CW'(N - 1);
                                    opb_r     <= rs_mag_s;
                                    prod_r    <= {{W{1'b0}}, rt_mag_s};
                                end
                                OP_DIV, OP_DIVU: begin
                                    busy_r   <= 1'b1;
                                    is_div_r <= 1'b1;
                                    if (i_rt_data == '0) begin
                                        state_r       <= S_FIX;
                                        dbz_pending_r <= 1'b1;
                                    end else begin
                                        state_r   <= S_DIV;
                                        neg_res_r <= rs_neg_s ^ rt_neg_s;
                                        neg_rem_r <= rs_neg_s;
                                        cnt_r     <= CW'(W - 1);
                                        opb_r     <= rt_mag_s;
                                        prod_r    <= {{W{1'b0}}, rs_mag_s};
                                    end
                                end
                                OP_MTHI: hi_r <= i_rs_data;
                                OP_MTLO: lo_r <= i_rs_data;
                                default: state_r <= S_IDLE;
                            endcase
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_MUL: begin
                        prod_r <= mul_next_s;
                        if (cnt_r == '0) begin
                            state_r <= S_FIX;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                    S_DIV: begin
                        prod_r <= div_next_s;
                        if (cnt_r == '0) begin
                            state_r <= S_FIX;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end
                    S_FIX: begin
                        if (!dbz_pending_r) begin
                            if (is_div_r) begin
                                hi_r <= rem_res_s;
                                lo_r <= quo_res_s;
                            end else begin
                                hi_r <= mul_res_s[2*W-1:W];
                                lo_r <= mul_res_s[W-1:0];
                            end
                        end else begin
                            hi_r <= hi_r;
                        end
                        done_r        <= 1'b1;
                        dbz_r         <= dbz_pending_r;
                        dbz_pending_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dbz_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//   Directed-vector bench for ex_muldiv_unit. One instance uses one multiplier
//   bit per cycle, a second one uses four. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic        valid4;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;

    logic        busy1, done1, dbz1;
    logic [31:0] hi1, lo1;
    logic        busy4, done4, dbz4;
    logic [31:0] hi4, lo4;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset_n), .i_valid(valid), .i_op(op),
        .i_rs_data(rs), .i_rt_data(rt), .i_flush(flush),
        .o_busy(busy1), .o_done(done1), .o_div_by_zero(dbz1),
        .o_hi(hi1), .o_lo(lo1)
    );

    ex_muldiv_unit #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset_n), .i_valid(valid4), .i_op(op),
        .i_rs_data(rs), .i_rt_data(rt), .i_flush(flush),
        .o_busy(busy4), .o_done(done4), .o_div_by_zero(dbz4),
        .o_hi(hi4), .o_lo(lo4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op to the selected instance, count busy cycles, sample done.
    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int nb, output bit dn, output bit dz);
        @(negedge clk);
        op = o; rs = a; rt = b;
        if (sel) valid4 = 1'b1; else valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; valid4 = 1'b0;
        nb = 0;
        while ((sel ? busy4 : busy1) && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        dn = sel ? done4 : done1;
        dz = sel ? dbz4 : dbz1;
    endtask

    int nb;
    bit dn, dz, seen;

    initial begin
        reset_n = 1'b0; valid = 1'b0; valid4 = 1'b0; flush = 1'b0;
        op = 3'd0; rs = 32'd0; rt = 32'd0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {63'd0, busy1}, 64'd0);
        check_val("rst_done", {62'd0, done1, dbz1}, 64'd0);
        check_val("rst_hilo", {hi1, lo1}, 64'd0);
        reset_n = 1'b1;

        // MULT -3 * 7 = -21
        run_op(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd7, nb, dn, dz);
        check_val("mult_busy", 64'(nb), 64'd33);
        check_val("mult_done", {62'd0, dn, dz}, 64'd2);
        check_val("mult_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check_val("mult_done_pulse", {63'd0, done1}, 64'd0);

        // MULT 5 * -6 = -30
        run_op(1'b0, 3'd1, 32'd5, 32'hFFFF_FFFA, nb, dn, dz);
        check_val("mult2_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFE2);

        // MULTU max*max
        run_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, dn, dz);
        check_val("multu_busy", 64'(nb), 64'd33);
        check_val("multu_hilo", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);

        // Same on four-bits-per-cycle instance
        run_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, dn, dz);
        check_val("multu4_busy", 64'(nb), 64'd9);
        check_val("multu4_done", {62'd0, dn, dz}, 64'd2);
        check_val("multu4_hilo", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);

        // DIV -7 / 2 -> q=-3, r=-1
        run_op(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, nb, dn, dz);
        check_val("div_busy", 64'(nb), 64'd33);
        check_val("div_done", {62'd0, dn, dz}, 64'd2);
        check_val("div_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 7 / -2 -> q=-3, r=1
        run_op(1'b0, 3'd3, 32'd7, 32'hFFFF_FFFE, nb, dn, dz);
        check_val("div_negdvs_hilo", {hi1, lo1}, 64'h0000_0001_FFFF_FFFD);

        // DIV MIN_INT / -1 wraps
        run_op(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb, dn, dz);
        check_val("div_minint_hilo", {hi1, lo1}, 64'h0000_0000_8000_0000);

        // DIVU 100 / 7
        run_op(1'b0, 3'd4, 32'd100, 32'd7, nb, dn, dz);
        check_val("divu_hilo", {hi1, lo1}, 64'h0000_0002_0000_000E);

        // MTHI / MTLO
        run_op(1'b0, 3'd5, 32'h0000_1234, 32'd0, nb, dn, dz);
        check_val("mthi_busy", 64'(nb), 64'd0);
        check_val("mthi_done", {63'd0, dn}, 64'd0);
        run_op(1'b0, 3'd6, 32'h0000_5678, 32'd0, nb, dn, dz);
        check_val("mt_hilo", {hi1, lo1}, 64'h0000_1234_0000_5678);

        // Divide by zero
        run_op(1'b0, 3'd3, 32'd55, 32'd0, nb, dn, dz);
        check_val("dbz_busy", 64'(nb), 64'd1);
        check_val("dbz_flags", {62'd0, dn, dz}, 64'd3);
        check_val("dbz_hilo", {hi1, lo1}, 64'h0000_1234_0000_5678);

        // Flush at busy cycle 10
        @(negedge clk);
        op = 3'd1; rs = 32'd3; rt = 32'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        check_val("flush10_busy_pre", {63'd0, busy1}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush10_busy", {62'd0, busy1, done1}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done1) seen = 1'b1;
        end
        check_val("flush10_nodone", {63'd0, seen}, 64'd0);
        check_val("flush10_hilo", {hi1, lo1}, 64'h0000_1234_0000_5678);

        // Flush in FIX cycle
        @(negedge clk);
        op = 3'd1; rs = 32'd3; rt = 32'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (32) @(negedge clk);
        check_val("flushfix_busy_pre", {63'd0, busy1}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flushfix_busy", {62'd0, busy1, done1}, 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done1) seen = 1'b1;
        end
        check_val("flushfix_nodone", {63'd0, seen}, 64'd0);
        check_val("flushfix_hilo", {hi1, lo1}, 64'h0000_1234_0000_5678);

        // Flush together with valid: nothing accepted
        @(negedge clk);
        op = 3'd5; rs = 32'hDEAD_BEEF; valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        check_val("flush_valid_hilo", {hi1, lo1}, 64'h0000_1234_0000_5678);

        // Reset in DIV busy cycle 5
        @(negedge clk);
        op = 3'd4; rs = 32'd100; rt = 32'd7; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rstdiv_busy_pre", {63'd0, busy1}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("rstdiv_flags", {61'd0, busy1, done1, dbz1}, 64'd0);
        check_val("rstdiv_hilo", {hi1, lo1}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Valid while busy is ignored
        @(negedge clk);
        op = 3'd2; rs = 32'd6; rt = 32'd7; valid = 1'b1;
        @(negedge clk);
        nb = 0;
        while (busy1 && nb < 200) begin
            nb++;
            if (nb <= 3) begin
                op = 3'd2; rs = 32'd2; rt = 32'd2; valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check_val("ignore_busy", 64'(nb), 64'd33);
        check_val("ignore_done", {63'd0, done1}, 64'd1);
        check_val("ignore_hilo", {hi1, lo1}, 64'd42);
        @(negedge clk);
        check_val("ignore_idle", {63'd0, busy1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
